// File: rtl/mem_arbiter.sv
// Purpose: two-port round-robin arbiter/sequencer onto a single shared block-memory port, with range checking.
// Latency: write ack at N+2, read ack (with data) at N+3, range-error ack at N+1 after the IDLE grant cycle N.
// Backpressure: one transaction in flight; requesters hold req/we/addr/wdata until their ack, losers simply wait.
module mem_arbiter #(
    parameter int size       = 1024,
    parameter int blocks     = 4,
    parameter int log_size   = 10,
    parameter int cell_width = 32,
    localparam int width     = blocks * cell_width
) (
    input  logic                in_clk,
    input  logic                in_reset,
    input  logic                in_req0,
    input  logic                in_req1,
    input  logic                in_we0,
    input  logic                in_we1,
    input  logic [log_size-1:0] in_addr0,
    input  logic [log_size-1:0] in_addr1,
    input  logic [width-1:0]    in_wdata0,
    input  logic [width-1:0]    in_wdata1,
    output logic                out_ack0,
    output logic                out_ack1,
    output logic                out_err0,
    output logic                out_err1,
    output logic [width-1:0]    out_rdata,
    output logic                out_busy,
    output logic [log_size-1:0] out_mem_address,
    output logic [width-1:0]    out_mem_data,
    output logic                out_mem_read_en,
    output logic                out_mem_write_en,
    input  logic [width-1:0]    in_mem_data
);

    // One extra bit so addr + blocks cannot wrap before the compare.
    localparam int AW1 = log_size + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_LATCH,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_prio;
    logic                r_id;
    logic                r_we;
    logic                r_err;
    logic [log_size-1:0] r_addr;
    logic [width-1:0]    r_wdata;
    logic [width-1:0]    r_rdata;

    logic                w_take;
    logic                w_gnt_id;
    logic                w_gnt_we;
    logic [log_size-1:0] w_gnt_addr;
    logic [width-1:0]    w_gnt_wdata;
    logic [AW1-1:0]      w_end;
    logic                w_range_err;

    // Winner selection: a lone requester wins outright, a tie goes to the priority pointer.
    assign w_gnt_id    = (in_req0 & in_req1) ? r_prio : in_req1;
    assign w_gnt_we    = w_gnt_id ? in_we1    : in_we0;
    assign w_gnt_addr  = w_gnt_id ? in_addr1  : in_addr0;
    assign w_gnt_wdata = w_gnt_id ? in_wdata1 : in_wdata0;
    assign w_end       = {1'b0, w_gnt_addr} + AW1'(blocks);
    assign w_range_err = (w_end > AW1'(size));

    // State register.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next           = r_state;
        w_take           = 1'b0;
        out_mem_write_en = 1'b0;
        out_mem_read_en  = 1'b0;
        out_ack0         = 1'b0;
        out_ack1         = 1'b0;
        out_err0         = 1'b0;
        out_err1         = 1'b0;
        out_busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (in_req0 | in_req1) begin
                    w_take = 1'b1;
                    if (w_range_err) begin
                        w_next = S_RESP;
                    end else if (w_gnt_we) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_WRITE: begin
                out_mem_write_en = 1'b1;
                w_next           = S_RESP;
            end
            S_READ: begin
                out_mem_read_en = 1'b1;
                w_next          = S_LATCH;
            end
            S_LATCH: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                out_ack0 = ~r_id;
                out_ack1 = r_id;
                out_err0 = ~r_id & r_err;
                out_err1 = r_id & r_err;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the granted transaction, rotate priority, capture read data at the end of LATCH.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_prio  <= 1'b0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_take) begin
                r_id    <= w_gnt_id;
                r_we    <= w_gnt_we;
                r_err   <= w_range_err;
                r_addr  <= w_gnt_addr;
                r_wdata <= w_gnt_wdata;
                r_prio  <= ~w_gnt_id;
            end
            if (r_state == S_LATCH) begin
                r_rdata <= in_mem_data;
            end
        end
    end

    // r_we is kept for observability of the latched transaction; the FSM path already encodes it.
    logic w_unused_we;
    assign w_unused_we = r_we;

    assign out_mem_address = r_addr;
    assign out_mem_data    = r_wdata;
    assign out_rdata       = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a behavioural one-cycle-latency memory and a scoreboard.
// Latency: checks ack timing per transaction type against the request's IDLE cycle.
// Backpressure: requesters hold their inputs until ack, as the arbiter expects.
module tb_mem_arbiter;

    localparam int SIZE = 1024;
    localparam int BLK  = 4;
    localparam int LS   = 10;
    localparam int CW   = 32;
    localparam int W    = BLK * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_req0 = 1'b0, in_req1 = 1'b0, in_we0 = 1'b0, in_we1 = 1'b0;
    logic [LS-1:0] in_addr0 = '0, in_addr1 = '0;
    logic [W-1:0]  in_wdata0 = '0, in_wdata1 = '0;
    logic          out_ack0, out_ack1, out_err0, out_err1, out_busy;
    logic          out_mem_read_en, out_mem_write_en;
    logic [W-1:0]  out_rdata, out_mem_data;
    logic [LS-1:0] out_mem_address;
    logic [W-1:0]  in_mem_data;

    always #5 clk = ~clk;

    mem_arbiter #(.size(SIZE), .blocks(BLK), .log_size(LS), .cell_width(CW)) dut (
        .in_clk(clk), .in_reset(rst_n),
        .in_req0(in_req0), .in_req1(in_req1), .in_we0(in_we0), .in_we1(in_we1),
        .in_addr0(in_addr0), .in_addr1(in_addr1), .in_wdata0(in_wdata0), .in_wdata1(in_wdata1),
        .out_ack0(out_ack0), .out_ack1(out_ack1), .out_err0(out_err0), .out_err1(out_err1),
        .out_rdata(out_rdata), .out_busy(out_busy), .out_mem_address(out_mem_address),
        .out_mem_data(out_mem_data), .out_mem_read_en(out_mem_read_en),
        .out_mem_write_en(out_mem_write_en), .in_mem_data(in_mem_data)
    );

    // Behavioural memory: registered read, one-cycle latency.
    logic [CW-1:0] mem [SIZE];
    always @(posedge clk) begin
        if (out_mem_write_en)
            for (int k = 0; k < BLK; k++) mem[(int'(out_mem_address) + k) % SIZE] <= out_mem_data[k*CW +: CW];
        if (out_mem_read_en)
            for (int k = 0; k < BLK; k++) in_mem_data[k*CW +: CW] <= mem[(int'(out_mem_address) + k) % SIZE];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic         id;
        logic         err;
        logic         rd;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference copy of memory contents, updated in the order transactions are expected to be granted.
    logic [CW-1:0] sh [SIZE];

    task automatic push_txn(input logic p, input logic we, input logic [LS-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.id   = p;
        e.err  = (int'(a) + BLK > SIZE);
        e.rd   = !we;
        e.data = '0;
        if (!e.err) begin
            for (int k = 0; k < BLK; k++) begin
                if (we) sh[int'(a) + k] = d[k*CW +: CW];
                else    e.data[k*CW +: CW] = sh[int'(a) + k];
            end
        end
        sb.push_back(e);
    endtask

    task automatic set_port(input logic p, input logic r, input logic we, input logic [LS-1:0] a, input logic [W-1:0] d);
        if (p) begin
            in_req1 = r; in_we1 = we; in_addr1 = a; in_wdata1 = d;
        end else begin
            in_req0 = r; in_we0 = we; in_addr0 = a; in_wdata0 = d;
        end
    endtask

    // Scoreboard: each ack pops the oldest expectation and checks port, error flag and read data.
    logic [W-1:0] exp_rd = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (out_mem_read_en || out_mem_write_en))
            chk("en_excl", W'(out_mem_read_en & out_mem_write_en), '0);
        if (rst_n && (out_ack0 || out_ack1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", W'({out_ack1, out_ack0}), '0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", W'(out_ack1), W'(e.id));
                chk("ack_excl", W'(out_ack0 & out_ack1), '0);
                chk("err_flag", W'(e.id ? out_err1 : out_err0), W'(e.err));
                chk("err_other", W'(e.id ? out_err0 : out_err1), '0);
                if (e.rd && !e.err) exp_rd = e.data;
                chk("rdata", out_rdata, exp_rd);
            end
        end
    end

    // Single transaction on one port, checking enable timing and ack latency.
    task automatic do_txn(input logic p, input logic we, input logic [LS-1:0] a, input logic [W-1:0] d);
        int   ack_k = 0, en_k = 0, en_cnt = 0, lat;
        logic busy_at_ack = 1'b0;
        logic [LS-1:0] en_addr = '0;
        logic err;
        err = (int'(a) + BLK > SIZE);
        lat = err ? 1 : (we ? 2 : 3);
        push_txn(p, we, a, d);
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, d);
        @(negedge clk);
        chk("idle_busy", W'(out_busy), '0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_mem_read_en || out_mem_write_en) begin
                en_cnt++; en_k = k; en_addr = out_mem_address;
                chk("en_kind", W'(out_mem_write_en), W'(we));
            end
            if (p ? out_ack1 : out_ack0) begin
                ack_k = k; busy_at_ack = out_busy;
                break;
            end
        end
        chk("ack_latency", W'(ack_k), W'(lat));
        chk("en_count", W'(en_cnt), W'(err ? 0 : 1));
        if (!err) begin
            chk("en_cycle", W'(en_k), W'(1));
            chk("en_addr", W'(en_addr), W'(a));
        end
        chk("ack_busy", W'(busy_at_ack), W'(1));
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    // Per-port transaction lists for concurrent runs where each requester keeps req high back to back.
    logic          d_we   [2][8];
    logic [LS-1:0] d_addr [2][8];
    logic [W-1:0]  d_dat  [2][8];
    int            d_n    [2];
    int            ack_cyc[2][8];

    task automatic port_run(input logic p);
        logic got;
        if (d_n[p] == 0) return;
        @(posedge clk); #1;
        set_port(p, 1'b1, d_we[p][0], d_addr[p][0], d_dat[p][0]);
        for (int j = 0; j < d_n[p]; j++) begin
            got = 1'b0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (p ? out_ack1 : out_ack0) begin
                    got = 1'b1;
                    break;
                end
            end
            chk(p ? "drv1_ack" : "drv0_ack", W'(got), W'(1));
            ack_cyc[p][j] = cyc;
            @(posedge clk); #1;
            if (j + 1 < d_n[p]) set_port(p, 1'b1, d_we[p][j+1], d_addr[p][j+1], d_dat[p][j+1]);
            else                set_port(p, 1'b0, 1'b0, '0, '0);
        end
    endtask

    // Expected grant order with both requesters pending from prio 0: alternate 0,1,0,1 until one runs out.
    task automatic run_pair();
        int   i0 = 0, i1 = 0;
        logic turn = 1'b0;
        while (i0 < d_n[0] || i1 < d_n[1]) begin
            if (i1 >= d_n[1] || (turn == 1'b0 && i0 < d_n[0])) begin
                push_txn(1'b0, d_we[0][i0], d_addr[0][i0], d_dat[0][i0]);
                i0++; turn = 1'b1;
            end else begin
                push_txn(1'b1, d_we[1][i1], d_addr[1][i1], d_dat[1][i1]);
                i1++; turn = 1'b0;
            end
        end
        fork
            port_run(1'b0);
            port_run(1'b1);
        join
    endtask

    initial begin
        logic [W-1:0] pat;
        for (int i = 0; i < SIZE; i++) sh[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(out_busy), '0);
        chk("rst_ack", W'({out_ack1, out_ack0, out_err1, out_err0}), '0);
        chk("rst_en", W'({out_mem_read_en, out_mem_write_en}), '0);
        chk("rst_rdata", out_rdata, '0);
        rst_n = 1'b1;

        do_txn(1'b0, 1'b1, 10'h010, 128'h44444444_33333333_22222222_11111111);
        do_txn(1'b1, 1'b0, 10'h010, '0);

        // Both ports write continuously: grants must alternate starting with port 0.
        d_n[0] = 3; d_n[1] = 3;
        for (int j = 0; j < 3; j++) begin
            d_we[0][j] = 1'b1; d_addr[0][j] = LS'(10'h100 + 4*j); d_dat[0][j] = {4{32'hA000_0000 + 32'(j)}};
            d_we[1][j] = 1'b1; d_addr[1][j] = LS'(10'h200 + 4*j); d_dat[1][j] = {4{32'hB000_0000 + 32'(j)}};
        end
        run_pair();
        do_txn(1'b1, 1'b0, 10'h108, '0);
        do_txn(1'b0, 1'b0, 10'h204, '0);

        // Range boundary: 0x3FD overruns, 0x3FC fits exactly.
        do_txn(1'b0, 1'b0, 10'h3FD, '0);
        pat = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
        do_txn(1'b0, 1'b1, 10'h3FC, pat);
        do_txn(1'b0, 1'b0, 10'h3FC, '0);

        // Reset during LATCH of a port-0 read: transaction dropped, outputs clear asynchronously.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 10'h010, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_read_en", W'(out_mem_read_en), W'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ack", W'({out_ack1, out_ack0, out_err1, out_err0}), '0);
        chk("rstmid_busy", W'(out_busy), '0);
        chk("rstmid_en", W'({out_mem_read_en, out_mem_write_en}), '0);
        chk("rstmid_rdata", out_rdata, '0);
        chk("rstmid_addr", W'(out_mem_address), '0);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous reads after reset: prio is back at 0 so port 0 wins first.
        d_n[0] = 1; d_n[1] = 1;
        d_we[0][0] = 1'b0; d_addr[0][0] = 10'h010; d_dat[0][0] = '0;
        d_we[1][0] = 1'b0; d_addr[1][0] = 10'h108; d_dat[1][0] = '0;
        run_pair();
        chk("post_rst_order", W'(ack_cyc[1][0] > ack_cyc[0][0]), W'(1));

        // Port 0 back-to-back writes: next grant happens in the IDLE cycle right after the ack.
        d_n[0] = 2; d_n[1] = 0;
        d_we[0][0] = 1'b1; d_addr[0][0] = 10'h020; d_dat[0][0] = {4{32'h1234_5678}};
        d_we[0][1] = 1'b1; d_addr[0][1] = 10'h024; d_dat[0][1] = 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA;
        run_pair();
        chk("b2b_gap", W'(ack_cyc[0][1] - ack_cyc[0][0]), W'(3));
        do_txn(1'b0, 1'b0, 10'h024, '0);
        do_txn(1'b1, 1'b0, 10'h020, '0);

        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        chk("sb_drain", W'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
